fifo_rd_stream: RTL and testbench

Read-side consumer for the async FIFO, in the rd_clk domain downstream of the read-pointer/empty logic. Drives rd_en into the pointer/empty logic and captures registered-memory read data into a 2-entry prefetch/skid buffer. Presents the data as a valid/ready stream. Also computes read-side occupancy and almost_empty from the synchronized write Gray pointer and the local read Gray pointer.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_rd_stream_if.sv | 22 ++
 rtl/fifo_skid_buf.sv | 71 +++++++
 rtl/fifo_rd_stream.sv | 86 ++++++++
 tb/tb_fifo_rd_stream.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the async FIFO read side
package fifo_pkg;

    localparam int DEF_ADDR_SIZE = 4;
    localparam int DEPTH         = 2 ** DEF_ADDR_SIZE;
    localparam int GRAY_MAX_W    = 32;

    typedef enum logic [1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2
    } buf_state_t;

    // Generic width: a zero-extended Gray code converts to a zero-extended binary value.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - valid/ready word stream leaving the FIFO read side
interface fifo_rd_stream_if #(
    parameter int DATA_SIZE = 8
) ();

    logic                 m_valid;
    logic                 m_ready;
    logic [DATA_SIZE-1:0] m_data;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );

endinterface

// File: rtl/fifo_skid_buf.sv
// rtl/fifo_skid_buf.sv - two-entry prefetch buffer holding words read from FIFO memory
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] push_data,
    input  logic                 pop,
    output logic [1:0]           count,
    output logic [DATA_SIZE-1:0] head_data
);

    buf_state_t           state_q, state_d;
    logic [DATA_SIZE-1:0] head_q, head_d;
    logic [DATA_SIZE-1:0] tail_q, tail_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= B0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // The upstream credit logic never pushes into a full buffer without a pop.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            B0: begin
                if (push) begin
                    head_d  = push_data;
                    state_d = B1;
                end
            end
            B1: begin
                if (push && pop) begin
                    head_d = push_data;
                end else if (push) begin
                    tail_d  = push_data;
                    state_d = B2;
                end else if (pop) begin
                    state_d = B0;
                end
            end
            B2: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = push_data;
                    end else begin
                        state_d = B1;
                    end
                end
            end
            default: state_d = B0;
        endcase
    end

    assign count     = state_q;
    assign head_data = head_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - read-side consumer: pop pacing, prefetch buffer and occupancy flags
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE = 4,
    parameter int DATA_SIZE = 8,
    parameter int AE_THRESH = 2
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    input  logic                 empty,
    output logic                 rd_en,
    input  logic [DATA_SIZE-1:0] rd_data,
    input  logic [ADDR_SIZE:0]   wr_ptr_addr_sync,
    input  logic [ADDR_SIZE:0]   rd_addr_grey,
    output logic [ADDR_SIZE:0]   rd_level,
    output logic                 almost_empty,
    fifo_rd_stream_if.master     m
);

    localparam int PTR_W = ADDR_SIZE + 1;
    localparam logic [PTR_W-1:0] LEVEL_MAX = {1'b1, {ADDR_SIZE{1'b0}}};

    logic [1:0]           count;
    logic [DATA_SIZE-1:0] head_data;
    logic                 pop;
    logic [2:0]           outstanding;
    logic                 inflight_q, inflight_d;
    logic [PTR_W-1:0]     rd_level_q, rd_level_d;
    logic                 almost_empty_q, almost_empty_d;

    assign m.m_valid = (count != 2'd0);
    assign m.m_data  = head_data;
    assign pop       = m.m_valid & m.m_ready;

    // Words already committed (buffered or returning from memory) must leave room
    // for the new one, counting the slot freed by this cycle's pop.
    always_comb begin
        outstanding = {1'b0, count} + {2'b00, inflight_q};
        rd_en       = !empty && (outstanding < (3'd2 + {2'b00, pop}));
        inflight_d  = rd_en;
    end

    always_comb begin
        rd_level_d     = PTR_W'(gray2bin(GRAY_MAX_W'(wr_ptr_addr_sync))
                              - gray2bin(GRAY_MAX_W'(rd_addr_grey)));
        almost_empty_d = (rd_level_d <= PTR_W'(AE_THRESH));
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            inflight_q     <= 1'b0;
            rd_level_q     <= '0;
            almost_empty_q <= 1'b1;
        end else begin
            inflight_q     <= inflight_d;
            rd_level_q     <= rd_level_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign rd_level     = rd_level_q;
    assign almost_empty = almost_empty_q;

    fifo_skid_buf #(
        .DATA_SIZE (DATA_SIZE)
    ) u_skid_buf (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .push      (inflight_q),
        .push_data (rd_data),
        .pop       (pop),
        .count     (count),
        .head_data (head_data)
    );

    a_no_pop_when_empty: assert property (@(posedge rd_clk) disable iff (rd_rst)
        !(rd_en && empty));
    a_count_max: assert property (@(posedge rd_clk) disable iff (rd_rst)
        count <= 2'd2);
    a_outstanding_max: assert property (@(posedge rd_clk) disable iff (rd_rst)
        outstanding <= 3'd2);
    a_level_max: assert property (@(posedge rd_clk) disable iff (rd_rst)
        rd_level_q <= LEVEL_MAX);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - randomized bench for the FIFO read-side stream
module tb_fifo_rd_stream;
    import fifo_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int AE = 2;
    localparam int PW = AW + 1;

    logic          rd_clk = 1'b0;
    logic          rd_rst = 1'b1;
    logic          empty  = 1'b1;
    logic          rd_en;
    logic [DW-1:0] rd_data = '0;
    logic [PW-1:0] wr_ptr_addr_sync = '0;
    logic [PW-1:0] rd_addr_grey = '0;
    logic [PW-1:0] rd_level;
    logic          almost_empty;

    fifo_rd_stream_if #(.DATA_SIZE(DW)) s ();

    fifo_rd_stream #(
        .ADDR_SIZE (AW),
        .DATA_SIZE (DW),
        .AE_THRESH (AE)
    ) dut (
        .rd_clk           (rd_clk),
        .rd_rst           (rd_rst),
        .empty            (empty),
        .rd_en            (rd_en),
        .rd_data          (rd_data),
        .wr_ptr_addr_sync (wr_ptr_addr_sync),
        .rd_addr_grey     (rd_addr_grey),
        .rd_level         (rd_level),
        .almost_empty     (almost_empty),
        .m                (s)
    );

    always #5 rd_clk = ~rd_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: words still in the FIFO memory, and words popped but not yet accepted.
    logic [DW-1:0] mem_q[$];
    logic [DW-1:0] exp_q[$];
    int            iss_q[$];
    bit            issued = 1'b0;
    logic [DW-1:0] pend = '0;
    bit            hold_empty = 1'b0;
    int            ready_mode = 1;
    logic [PW-1:0] wbin_v = '0, rbin_v = '0;
    logic [PW-1:0] lvl_d1 = '0, lvl_d2 = '0;
    int            lvl_age = 0;
    bit            stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;

    bit            s_valid, s_rd_en, s_ae;
    logic [DW-1:0] s_data;
    logic [PW-1:0] s_level;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic sample();
        int outst;
        bit pop, exp_valid, exp_rd_en;
        @(negedge rd_clk);
        s_valid = s.m_valid;
        s_data  = s.m_data;
        s_rd_en = rd_en;
        s_level = rd_level;
        s_ae    = almost_empty;
        if (!rd_rst) begin
            outst     = exp_q.size();
            exp_valid = (outst > 0) && (iss_q[0] <= cyc - 2);
            check_eq("m_valid", 32'(s_valid), 32'(exp_valid));
            pop       = s_valid && s.m_ready;
            exp_rd_en = !empty && ((outst - int'(pop)) < 2);
            check_eq("rd_en", 32'(s_rd_en), 32'(exp_rd_en));
            if (stall_prev)
                check_eq("stall_hold", 32'({s_valid, s_data}), 32'({1'b1, stall_data}));
            stall_prev = s_valid && !s.m_ready;
            stall_data = s_data;
            if (pop && outst > 0) begin
                check_eq("pop_data", 32'(s_data), 32'(exp_q[0]));
                void'(exp_q.pop_front());
                void'(iss_q.pop_front());
            end
            if (s_rd_en && mem_q.size() > 0) begin
                pend = mem_q.pop_front();
                exp_q.push_back(pend);
                iss_q.push_back(cyc);
                issued = 1'b1;
            end else begin
                issued = 1'b0;
            end
            if (lvl_age >= 2) begin
                check_eq("rd_level", 32'(s_level), 32'(lvl_d2));
                check_eq("almost_empty", 32'(s_ae), 32'(lvl_d2 <= PW'(AE)));
                check_eq("level_range", 32'(s_level <= PW'(DEPTH)), 32'd1);
            end
        end else begin
            stall_prev = 1'b0;
            issued     = 1'b0;
        end
    endtask

    task automatic drive();
        @(posedge rd_clk);
        #1;
        cyc++;
        rd_data          = issued ? pend : DW'($urandom);
        empty            = hold_empty || (mem_q.size() == 0);
        s.m_ready        = (ready_mode == 2) ? 1'($urandom % 2) : (ready_mode == 1);
        wr_ptr_addr_sync = to_gray(wbin_v);
        rd_addr_grey     = to_gray(rbin_v);
        lvl_d2           = lvl_d1;
        lvl_d1           = wbin_v - rbin_v;
        if (rd_rst) lvl_age = 0;
        else        lvl_age++;
    endtask

    task automatic cycle();
        sample();
        drive();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        s.m_ready = 1'b1;

        // Reset hold and idle release.
        repeat (2) cycle();
        check_eq("rst_valid", 32'(s_valid), 32'd0);
        check_eq("rst_data", 32'(s_data), 32'd0);
        check_eq("rst_rd_en", 32'(s_rd_en), 32'd0);
        check_eq("rst_level", 32'(s_level), 32'd0);
        check_eq("rst_ae", 32'(s_ae), 32'd1);
        rd_rst = 1'b0;
        repeat (3) cycle();
        check_eq("idle_valid", 32'(s_valid), 32'd0);
        check_eq("idle_data", 32'(s_data), 32'd0);
        check_eq("idle_rd_en", 32'(s_rd_en), 32'd0);
        check_eq("idle_ae", 32'(s_ae), 32'd1);

        // Single-word latency.
        mem_q.push_back(8'hA5);
        cycle();
        cycle();
        check_eq("lat_T_rd_en", 32'(s_rd_en), 32'd1);
        cycle();
        check_eq("lat_T1", 32'({s_rd_en, s_valid}), 32'd0);
        cycle();
        check_eq("lat_T2", 32'({s_valid, s_data}), 32'h1A5);
        cycle();
        check_eq("lat_T3", 32'(s_valid), 32'd0);

        // Full-rate stream.
        for (int i = 0; i < 16; i++) mem_q.push_back(DW'(i));
        cycle();
        for (int i = 0; i < 18; i++) begin
            cycle();
            if (i < 16) check_eq("stream_rd_en", 32'(s_rd_en), 32'd1);
            if (i >= 2) check_eq("stream_out", 32'({s_valid, s_data}), 32'({1'b1, DW'(i - 2)}));
        end
        cycle();

        // Backpressure.
        ready_mode = 0;
        for (int i = 0; i < 6; i++) mem_q.push_back(DW'(8'h40 + i));
        cycle();
        pulses = 0;
        repeat (6) begin
            cycle();
            pulses += int'(s_rd_en);
        end
        check_eq("bp_pulses", 32'(pulses), 32'd2);
        check_eq("bp_head", 32'({s_valid, s_data}), 32'h140);
        ready_mode = 1;
        cycle();
        cycle();
        check_eq("bp_resume", 32'(s_rd_en), 32'd1);
        repeat (12) cycle();
        check_eq("bp_drain", 32'(exp_q.size() + mem_q.size()), 32'd0);

        // Level, including MSB wrap.
        wbin_v = 5'd5; rbin_v = 5'd0;
        repeat (3) cycle();
        check_eq("lvl_5", 32'({s_level, s_ae}), 32'({5'd5, 1'b0}));
        wbin_v = 5'd17; rbin_v = 5'd15;
        repeat (3) cycle();
        check_eq("lvl_wrap", 32'({s_level, s_ae}), 32'({5'd2, 1'b1}));

        // Reset with one word buffered and one in flight.
        ready_mode = 0;
        for (int i = 0; i < 4; i++) mem_q.push_back(DW'(8'h90 + i));
        cycle();
        cycle();
        cycle();
        #2;
        rd_rst = 1'b1;
        empty  = 1'b1;
        mem_q.delete();
        exp_q.delete();
        iss_q.delete();
        issued = 1'b0;
        #1;
        check_eq("rst_mid_valid", 32'(s.m_valid), 32'd0);
        check_eq("rst_mid_data", 32'(s.m_data), 32'd0);
        check_eq("rst_mid_rd_en", 32'(rd_en), 32'd0);
        repeat (2) cycle();
        rd_rst = 1'b0;
        ready_mode = 1;
        repeat (2) cycle();
        check_eq("post_rst_idle", 32'(s_valid), 32'd0);
        mem_q.push_back(8'h3C);
        cycle();
        cycle();
        cycle();
        cycle();
        check_eq("post_rst_first", 32'({s_valid, s_data}), 32'h13C);

        // Randomized traffic, backpressure, stale empty and pointer levels.
        ready_mode = 2;
        for (int n = 0; n < 3000; n++) begin
            if (($urandom % 2) == 1 && mem_q.size() < 6) mem_q.push_back(DW'($urandom));
            hold_empty = (($urandom % 5) == 0);
            if ((n % 4) == 0) begin
                rbin_v = PW'($urandom);
                wbin_v = rbin_v + PW'($urandom_range(0, DEPTH));
            end
            cycle();
        end

        hold_empty = 1'b0;
        ready_mode = 1;
        repeat (16) cycle();
        check_eq("final_drain", 32'(exp_q.size() + mem_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
